// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT spectrum capture block.
package fft_pkg;
    localparam int N_PTS  = 1024;
    localparam int ADDR_W = 10;
    localparam int DW     = 12;
    localparam int MAG_W  = 24;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, HOLD} state_t;
endpackage

// File: rtl/spectrum_ram.sv
// Simple dual-port spectrum RAM: one write port, one read port with registered read data.
module spectrum_ram
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [MAG_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [MAG_W-1:0]  rd_data
);
    logic [MAG_W-1:0] r_mem [N_PTS];
    logic [MAG_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
endmodule

// File: rtl/fft_spectrum_capture.sv
// Captures one FFT frame from an Avalon-ST source, stores |X|^2 per bin and tracks the peak bin.
module fft_spectrum_capture
    import fft_pkg::*;
#(
    parameter bit SKIP_DC = 1'b1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 source_valid,
    output logic                 source_ready,
    input  logic                 source_sop,
    input  logic                 source_eop,
    input  logic [1:0]           source_error,
    input  logic signed [DW-1:0] source_real,
    input  logic signed [DW-1:0] source_imag,
    input  logic                 frame_ack,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [MAG_W-1:0]     rd_data,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [ADDR_W-1:0]    peak_bin,
    output logic [MAG_W-1:0]     peak_mag
);
    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_count, w_count_next;
    logic                r_drain, w_drain_next;
    logic                w_accept, w_err, w_done_next;
    logic                w_pipe_in, w_pipe_first;
    logic [ADDR_W-1:0]   w_pipe_bin;
    logic signed [MAG_W-1:0] w_re_sq, w_im_sq;

    logic                r_s1_valid, r_s1_first;
    logic [ADDR_W-1:0]   r_s1_bin;
    logic [MAG_W-1:0]    r_s1_re, r_s1_im;
    logic                r_s2_valid, r_s2_first;
    logic [ADDR_W-1:0]   r_s2_bin;
    logic [MAG_W-1:0]    r_s2_mag;

    logic [MAG_W-1:0]    r_run_mag, w_run_mag_next;
    logic [ADDR_W-1:0]   r_run_bin, w_run_bin_next;
    logic [MAG_W-1:0]    r_peak_mag;
    logic [ADDR_W-1:0]   r_peak_bin;
    logic                r_frame_done, r_frame_err;

    assign source_ready = !rst && (r_state == IDLE || r_state == CAPTURE);
    assign w_accept     = source_valid && source_ready;
    assign w_re_sq      = source_real * source_real;
    assign w_im_sq      = source_imag * source_imag;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_drain_next = r_drain;
        w_err        = 1'b0;
        w_pipe_in    = 1'b0;
        w_pipe_first = 1'b0;
        w_pipe_bin   = r_count;
        case (r_state)
            IDLE: begin
                if (w_accept && source_sop) begin
                    if (source_eop || source_error != 2'b00) begin
                        w_err = 1'b1;
                    end else begin
                        w_state_next = CAPTURE;
                        w_count_next = ADDR_W'(1);
                        w_pipe_in    = 1'b1;
                        w_pipe_first = 1'b1;
                        w_pipe_bin   = '0;
                    end
                end
            end
            CAPTURE: begin
                if (w_accept) begin
                    w_pipe_in    = 1'b1;
                    w_pipe_first = source_sop;
                    w_pipe_bin   = source_sop ? '0 : r_count;
                    if (source_error != 2'b00 || (source_sop && source_eop)) begin
                        w_err        = 1'b1;
                        w_state_next = IDLE;
                    end else if (source_sop) begin
                        // Restart on a fresh sop; the aborted frame is still reported.
                        w_err        = 1'b1;
                        w_count_next = ADDR_W'(1);
                    end else if (source_eop) begin
                        if (r_count == ADDR_W'(N_PTS - 1)) begin
                            w_state_next = DRAIN;
                            w_drain_next = 1'b0;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = IDLE;
                        end
                    end else if (r_count == ADDR_W'(N_PTS - 1)) begin
                        w_err        = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_drain_next = 1'b1;
                if (r_drain) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_done_next = (r_state == DRAIN) && r_drain;

    // The first bin of a frame re-seeds the tracker; bin 0 is ignored when DC is skipped.
    always_comb begin
        w_run_mag_next = r_run_mag;
        w_run_bin_next = r_run_bin;
        if (r_s2_valid && r_s2_first) begin
            w_run_mag_next = SKIP_DC ? '0 : r_s2_mag;
            w_run_bin_next = '0;
        end else if (r_s2_valid && r_s2_mag > r_run_mag) begin
            w_run_mag_next = r_s2_mag;
            w_run_bin_next = r_s2_bin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_drain      <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_bin     <= '0;
            r_s1_re      <= '0;
            r_s1_im      <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_first   <= 1'b0;
            r_s2_bin     <= '0;
            r_s2_mag     <= '0;
            r_run_mag    <= '0;
            r_run_bin    <= '0;
            r_peak_mag   <= '0;
            r_peak_bin   <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_drain      <= w_drain_next;
            r_s1_valid   <= w_pipe_in;
            r_s1_first   <= w_pipe_first;
            r_s1_bin     <= w_pipe_bin;
            r_s1_re      <= w_re_sq;
            r_s1_im      <= w_im_sq;
            r_s2_valid   <= r_s1_valid;
            r_s2_first   <= r_s1_first;
            r_s2_bin     <= r_s1_bin;
            r_s2_mag     <= r_s1_re + r_s1_im;
            r_run_mag    <= w_run_mag_next;
            r_run_bin    <= w_run_bin_next;
            r_frame_done <= w_done_next;
            r_frame_err  <= w_err;
            if (w_done_next) begin
                r_peak_mag <= w_run_mag_next;
                r_peak_bin <= w_run_bin_next;
            end
        end
    end

    spectrum_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (r_s2_valid),
        .waddr   (r_s2_bin),
        .wdata   (r_s2_mag),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;
endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Randomized self-checking bench for fft_spectrum_capture with a frame-level reference model.
module tb_fft_spectrum_capture;
    localparam int N  = 1024;
    localparam int NB = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              source_valid, source_ready, source_sop, source_eop;
    logic [1:0]        source_error;
    logic signed [11:0] source_real, source_imag;
    logic              frame_ack;
    logic [9:0]        rd_addr;
    logic [23:0]       rd_data;
    logic              frame_done, frame_err;
    logic [9:0]        peak_bin;
    logic [23:0]       peak_mag;

    always #5 clk = ~clk;

    fft_spectrum_capture #(.SKIP_DC(1'b1)) dut (
        .clk(clk), .rst(rst),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_error(source_error),
        .source_real(source_real), .source_imag(source_imag),
        .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_err(frame_err),
        .peak_bin(peak_bin), .peak_mag(peak_mag)
    );

    int n_checks = 0, n_pass = 0;
    int cyc = 0, n_done = 0, n_errp = 0, done_cyc = 0, eop_cyc = 0;
    int b_re [NB];
    int b_im [NB];
    bit b_sop [NB];
    bit b_eop [NB];
    logic [1:0] b_err [NB];
    longint ref_ram [N];
    longint exp_mag = 0;
    int     exp_bin = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (frame_err) n_errp++;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int rnd(input int lim);
        return int'($urandom_range(2 * lim, 0)) - lim;
    endfunction

    task automatic clear_beats();
        for (int k = 0; k < NB; k++) begin
            b_re[k] = 0; b_im[k] = 0; b_sop[k] = 0; b_eop[k] = 0; b_err[k] = 2'b00;
        end
    endtask

    task automatic set_frame(input int base, input int lim);
        for (int k = 0; k < N; k++) begin
            b_re[base + k] = rnd(lim);
            b_im[base + k] = rnd(lim);
        end
        b_sop[base] = 1'b1;
        b_eop[base + N - 1] = 1'b1;
    endtask

    // Reference: |X|^2 per bin, peak over bins 1..N-1 (DC skipped), strictly greater wins.
    task automatic model_frame(input int base);
        longint m;
        exp_bin = 0;
        exp_mag = 0;
        for (int k = 0; k < N; k++) begin
            m = longint'(b_re[base + k]) * b_re[base + k] + longint'(b_im[base + k]) * b_im[base + k];
            ref_ram[k] = m;
            if (k > 0 && m > exp_mag) begin
                exp_mag = m;
                exp_bin = k;
            end
        end
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            source_valid = 1'b1;
            source_sop   = b_sop[k];
            source_eop   = b_eop[k];
            source_error = b_err[k];
            source_real  = 12'(b_re[k]);
            source_imag  = 12'(b_im[k]);
            if (b_eop[k]) eop_cyc = cyc;
        end
        @(posedge clk); #1;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
    endtask

    task automatic run_frame(input string tag, input int n, input int exp_done, input int exp_err);
        int d0, e0;
        d0 = n_done;
        e0 = n_errp;
        play(n);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_done_cnt"}, n_done - d0, exp_done);
        check_eq({tag, "_err_cnt"}, n_errp - e0, exp_err);
        if (exp_done != 0) check_eq({tag, "_latency"}, done_cyc - eop_cyc, 3);
        check_eq({tag, "_peak_bin"}, peak_bin, exp_bin);
        check_eq({tag, "_peak_mag"}, peak_mag, exp_mag);
        check_eq({tag, "_ready"}, source_ready, (exp_done != 0) ? 0 : 1);
        $display("frame %s: beats=%0d done=%0d err=%0d peak_bin=%0d peak_mag=%0d",
                 tag, n, n_done - d0, n_errp - e0, peak_bin, peak_mag);
    endtask

    task automatic do_ack(input string tag);
        @(posedge clk); #1 frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ack_ready"}, source_ready, 1);
    endtask

    task automatic readout_all(input string tag);
        int busy = 0;
        for (int a = 0; a <= N; a++) begin
            @(posedge clk); #1;
            if (a < N) rd_addr = 10'(a);
            @(negedge clk);
            if (source_ready) busy++;
            if (a > 0) check_eq($sformatf("%s_rd%0d", tag, a - 1), rd_data, ref_ram[a - 1]);
        end
        check_eq({tag, "_hold_ready"}, busy, 0);
    endtask

    task automatic readout_rand(input string tag, input int cnt);
        int prev = 0;
        for (int i = 0; i <= cnt; i++) begin
            @(posedge clk); #1;
            rd_addr = 10'($urandom_range(N - 1, 0));
            @(negedge clk);
            if (i > 0) check_eq($sformatf("%s_rd%0d", tag, prev), rd_data, ref_ram[prev]);
            prev = int'(rd_addr);
        end
    endtask

    initial begin
        int busy, j, d0, waited;
        rst = 1'b1; source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        source_error = 2'b00; source_real = '0; source_imag = '0; frame_ack = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", source_ready, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_err", frame_err, 0);
        check_eq("rst_peak_bin", peak_bin, 0);
        check_eq("rst_peak_mag", peak_mag, 0);
        check_eq("rst_rd_data", rd_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", source_ready, 1);

        // Ramp frame, long hold with two full readouts.
        clear_beats();
        for (int k = 0; k < N; k++) b_re[k] = k - 512;
        b_sop[0] = 1'b1; b_eop[N - 1] = 1'b1;
        model_frame(0);
        run_frame("ramp", N, 1, 0);
        busy = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (source_ready) busy++;
        end
        check_eq("ramp_hold50_ready", busy, 0);
        readout_all("ramp_a");
        readout_all("ramp_b");
        do_ack("ramp");

        // Extremes, acknowledged in the frame_done cycle itself.
        clear_beats();
        b_re[300] = -2048; b_im[300] = -2048;
        b_sop[0] = 1'b1; b_eop[N - 1] = 1'b1;
        model_frame(0);
        d0 = n_done;
        play(N);
        waited = 0;
        while (!frame_done && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ext_done_seen", frame_done, 1);
        check_eq("ext_latency", cyc - eop_cyc, 3);
        frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0;
        @(negedge clk);
        check_eq("ext_early_ack_ready", source_ready, 1);
        check_eq("ext_peak_bin", peak_bin, exp_bin);
        check_eq("ext_peak_mag", peak_mag, exp_mag);
        repeat (4) @(negedge clk);
        check_eq("ext_done_cnt", n_done - d0, 1);
        $display("frame ext: peak_bin=%0d peak_mag=%0d", peak_bin, peak_mag);

        // Random clean frames.
        for (int f = 0; f < 3; f++) begin
            clear_beats();
            set_frame(0, 2047);
            model_frame(0);
            run_frame($sformatf("rand%0d", f), N, 1, 0);
            readout_rand($sformatf("rand%0d", f), 24);
            do_ack($sformatf("rand%0d", f));
        end

        // Short frame: eop at bin 500.
        clear_beats();
        set_frame(0, 2047);
        b_eop[500] = 1'b1;
        run_frame("short", 501, 0, 1);

        // Nonzero source_error on a random beat.
        clear_beats();
        set_frame(0, 2047);
        j = int'($urandom_range(N - 1, 0));
        b_err[j] = 2'($urandom_range(3, 1));
        run_frame($sformatf("errbeat%0d", j), j + 1, 0, 1);

        // Mid-frame sop at bin 700 followed by a full frame; first part holds a huge bin.
        clear_beats();
        set_frame(700, 1000);
        for (int k = 0; k < 700; k++) begin
            b_re[k] = rnd(2047);
            b_im[k] = rnd(2047);
        end
        b_sop[0] = 1'b1;
        b_re[350] = -2048; b_im[350] = -2048;
        model_frame(700);
        run_frame("midsop", 700 + N, 1, 1);
        do_ack("midsop");

        // Reset in the middle of a capture.
        clear_beats();
        set_frame(0, 2047);
        play(400);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", source_ready, 0);
        check_eq("midrst_done", frame_done, 0);
        check_eq("midrst_err", frame_err, 0);
        check_eq("midrst_peak_bin", peak_bin, 0);
        check_eq("midrst_peak_mag", peak_mag, 0);
        check_eq("midrst_rd_data", rd_data, 0);
        exp_bin = 0;
        exp_mag = 0;
        j = n_errp;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_silent", n_errp - j, 0);

        // Junk beats in IDLE, then a frame with tied maxima at bins 10 and 20.
        clear_beats();
        for (int k = 0; k < 5; k++) begin
            b_re[k] = -2048; b_im[k] = -2048;
        end
        set_frame(5, 100);
        b_re[15] = 1000; b_im[15] = 0;
        b_re[25] = 1000; b_im[25] = 0;
        model_frame(5);
        run_frame("ties", 5 + N, 1, 0);
        readout_rand("ties", 24);
        do_ack("ties");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
